dotprod_loader: RTL and testbench
=================================

# dotprod_loader

Upstream feeder for the dot-product datapath. Accepts a length `n` on a config handshake, then streams `n` A-words followed by `n` B-words into two on-chip vector banks. It presents the banks to the consumer through asynchronous read ports, pulses `start` with `n_out` held stable, and waits for the consumer's `done` before accepting a new job. It replaces file-preloaded operand memories with a run-time loadable path.

## Interface
- `DATA_W`, 32, operand word width
- `DEPTH`, 256, entries per bank
- `ADDR_W`, 8, bank address width (log2 DEPTH)

- `sys_clk`  in  1  clock; all logic is rising-edge
- `sys_rst_n`  in  1  reset, synchronous and active-low
- `cfg_valid`  in  1  job request
- `cfg_n`  in  32  requested vector length
- `cfg_ready`  out  1  high in IDLE only
- `in_valid`  in  1  operand word valid
- `in_data`  in  DATA_W  operand word
- `in_ready`  out  1  high in LOAD_A/LOAD_B only
- `rd_addr_a`, `rd_addr_b`  in  ADDR_W  consumer read addresses
- `rd_data_a`, `rd_data_b`  out  DATA_W  combinational bank read data
- `start`  out  1  one-cycle job-start pulse
- `n_out`  out  32  accepted (clamped) length, stable from `start` until `done`
- `done`  in  1  consumer completion pulse
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  sticky: a `cfg_n` > DEPTH was received

## Operation
- States: IDLE, LOAD_A, LOAD_B, START, WAIT.
- IDLE: when `cfg_valid` is high, latch `n = min(cfg_n, DEPTH)` and set `err` if `cfg_n` > DEPTH. Clear the write counter. Go to LOAD_A, or to START if n == 0.
- LOAD_A: each beat (`in_valid & in_ready`) writes bank A at `wr_cnt` and increments it. On the beat that writes index n-1, clear `wr_cnt` and go to LOAD_B.
- LOAD_B: same behaviour into bank B. The beat at index n-1 goes to START.
- START: `start`=1 for exactly one cycle, then go to WAIT.
- WAIT: stay until `done`=1, then go to IDLE. `done` is ignored in all other states.
- `n_out` is updated only on config acceptance and holds its value through IDLE afterwards.
- Bank reads are asynchronous: `rd_data_x = bank_x[rd_addr_x]`. Reads are legal in any state. Data written on a beat is visible from the following cycle.
- Writes use a 9-bit `wr_cnt` and never exceed index DEPTH-1. With n == DEPTH the last write is at index 255, with no wrap.
- `err` clears only on reset. A clamped job still runs normally with n = DEPTH.

## Timing
- Reset values: `cfg_ready`=1, `in_ready`=0, `start`=0, `busy`=0, `err`=0, `n_out`=0, state=IDLE, `wr_cnt`=0. Bank contents are not reset.
- Reset asserted mid-load or mid-WAIT: the next edge returns to IDLE. Partially written data stays in the banks and is don't-care.
- Config accepted at edge T puts `in_ready`=1 in cycle T+1.
- At full input rate with n ≥ 1, `start` is high in cycle T+1+2n.
- n == 0: `start` is high in cycle T+1.
- `in_valid` gaps stall without losing count.
- A `done` sampled at edge D puts `cfg_ready`=1 in cycle D+1. A new config can be accepted at edge D+1.
- `cfg_valid` is ignored while `busy`.

## Structure
- Package `dotprod_pkg`: state enum `ldr_state_t`, constants `DOTPROD_DEPTH`=256, `DOTPROD_ADDR_W`=8, `DOTPROD_DATA_W`=32. The downstream consumer shares these constants.
- Sub-module `vec_bank`: DEPTH×DATA_W register array with one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port. It is instantiated twice, for A and B.
- The top level holds the FSM, `wr_cnt`, `n` register, `err`, and the handshake outputs.

## Test plan
- Reset, then idle: `cfg_ready`=1, `busy`=0, `start`=0, `err`=0, `n_out`=0.
- cfg_n=4, A={1,2,3,4}, B={5,6,7,8} at full rate: `start` at T+9, `n_out`=4, `rd_data_a`@2=3, `rd_data_b`@3=8. Return `done` and check `cfg_ready`=1 the next cycle.
- cfg_n=0: `start` at T+1 with no input beats accepted (`in_ready` never 1). `done` returns to IDLE.
- cfg_n=300: `err`=1, `n_out`=256. 512 beats are accepted and the 513th is refused (`in_ready`=0). Bank A[255] and B[255] hold the 256th and 512th words.
- Random `in_valid` gaps with n=3: the same bank contents as full rate, and `start` only after the 6th beat.
- `sys_rst_n`=0 during LOAD_B, then release: state is IDLE, `cfg_ready`=1, `err` cleared. `cfg_valid` pulses while in WAIT do not change `n_out`.

Source files
------------

// File: rtl/dotprod_pkg.sv
// Shared constants and loader state encoding for the dot-product datapath.
package dotprod_pkg;
  localparam int DOTPROD_DEPTH  = 256;
  localparam int DOTPROD_ADDR_W = 8;
  localparam int DOTPROD_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT
  } ldr_state_t;
endpackage

// File: rtl/vec_bank.sv
// Operand bank: register array with one synchronous write port and one
// combinational read port.
module vec_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dotprod_loader.sv
// Run-time loader for the dot-product operand banks: takes a job length,
// streams A then B words into the banks, then hands off via start/done.
module dotprod_loader
  import dotprod_pkg::*;
#(
  parameter int DATA_W = DOTPROD_DATA_W,
  parameter int DEPTH  = DOTPROD_DEPTH,
  parameter int ADDR_W = DOTPROD_ADDR_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_valid,
  input  logic [31:0]       cfg_n,
  output logic              cfg_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              start,
  output logic [31:0]       n_out,
  input  logic              done,
  output logic              busy,
  output logic              err
);
  localparam logic [31:0] DEPTH_N = 32'(DEPTH);

  ldr_state_t state, state_nx;
  logic [ADDR_W:0] wr_cnt;
  logic [31:0]     n_q;
  logic            accept, beat, last;

  assign accept = (state == IDLE) && cfg_valid;
  assign beat   = in_valid && in_ready;
  // n_q >= 1 whenever a load state is active, so n_q-1 never underflows there
  assign last   = {{(31-ADDR_W){1'b0}}, wr_cnt} == (n_q - 32'd1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cfg_valid) state_nx = (cfg_n == 32'd0) ? START : LOAD_A;
      LOAD_A:  if (beat && last) state_nx = LOAD_B;
      LOAD_B:  if (beat && last) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state  <= IDLE;
      wr_cnt <= '0;
      n_q    <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wr_cnt <= '0;
        n_q    <= (cfg_n > DEPTH_N) ? DEPTH_N : cfg_n;
        if (cfg_n > DEPTH_N) err <= 1'b1;
      end else if (beat) begin
        wr_cnt <= last ? '0 : wr_cnt + 1'b1;
      end
    end
  end

  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign start     = (state == START);
  assign busy      = (state != IDLE);
  assign n_out     = n_q;

  vec_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank_a (
    .clk   (sys_clk),
    .we    (beat && (state == LOAD_A)),
    .waddr (wr_cnt[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_addr_a),
    .rdata (rd_data_a)
  );

  vec_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank_b (
    .clk   (sys_clk),
    .we    (beat && (state == LOAD_B)),
    .waddr (wr_cnt[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_addr_b),
    .rdata (rd_data_b)
  );
endmodule

// File: tb/tb_dotprod_loader.sv
// Randomized self-checking bench for dotprod_loader against a queue/array model.
module tb_dotprod_loader;
  localparam int DW  = 32;
  localparam int DEP = 256;
  localparam int AW  = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [31:0]   cfg_n = '0;
  logic          cfg_ready;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          start;
  logic [31:0]   n_out;
  logic          done = 1'b0;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;

  logic [31:0] words[$];
  logic [31:0] mdl_a[DEP];
  logic [31:0] mdl_b[DEP];

  dotprod_loader dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cfg_valid(cfg_valid), .cfg_n(cfg_n), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .start(start), .n_out(n_out), .done(done), .busy(busy), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int clampn(input logic [31:0] x);
    return (x > 32'd256) ? 256 : int'(x);
  endfunction

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < 2*n; i++) words.push_back($urandom);
  endtask

  task automatic check_bank(input int a);
    rd_addr_a = AW'(a);
    rd_addr_b = AW'(a);
    #1;
    total++;
    if (rd_data_a !== mdl_a[a]) begin
      bad++; $display("FAIL bank_a[%0d] got=%h exp=%h", a, rd_data_a, mdl_a[a]);
    end
    total++;
    if (rd_data_b !== mdl_b[a]) begin
      bad++; $display("FAIL bank_b[%0d] got=%h exp=%h", a, rd_data_b, mdl_b[a]);
    end
  endtask

  task automatic do_cfg(input logic [31:0] n);
    cfg_n = n;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL cfg_accept busy=%b exp=1", busy); end
    total++;
    if (n_out !== 32'(clampn(n))) begin
      bad++; $display("FAIL n_out got=%0d exp=%0d", n_out, clampn(n));
    end
  endtask

  // Configure, stream the words queue (A half then B half), check start timing and bank contents.
  task automatic run_job(input logic [31:0] n_cfg, input bit gaps, output bit saw_ready);
    int n, idx, k;
    bit acc;
    n = clampn(n_cfg);
    idx = 0; k = 0; saw_ready = 0;
    do_cfg(n_cfg);
    while (start !== 1'b1 && k < 3000) begin
      if (in_ready === 1'b1) saw_ready = 1;
      if (idx < 2*n) begin
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data  = words[idx];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && (in_ready === 1'b1);
      tick();
      k++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    total++;
    if (start !== 1'b1) begin bad++; $display("FAIL start_timeout n=%0d cycles=%0d", n, k); end
    total++;
    if (idx != 2*n) begin bad++; $display("FAIL beats_before_start got=%0d exp=%0d", idx, 2*n); end
    if (!gaps) begin
      total++;
      if (k != 2*n) begin bad++; $display("FAIL start_latency got=%0d exp=%0d", k, 2*n); end
    end
    for (int i = 0; i < n; i++) begin
      mdl_a[i] = words[i];
      mdl_b[i] = words[n+i];
    end
    tick();
    total++;
    if (start !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL start_pulse start=%b busy=%b exp start=0 busy=1", start, busy);
    end
    if (n <= 8) begin
      for (int i = 0; i < n; i++) check_bank(i);
    end else if (n > 0) begin
      check_bank(0);
      check_bank(n-1);
      check_bank($urandom_range(0, n-1));
    end
  endtask

  task automatic finish_job(input int wait_cyc);
    repeat (wait_cyc) tick();
    total++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      bad++; $display("FAIL wait_hold busy=%b cfg_ready=%b exp 1/0", busy, cfg_ready);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL done_idle cfg_ready=%b busy=%b exp 1/0", cfg_ready, busy);
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || err !== 1'b0 ||
        n_out !== 32'd0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state cfg_ready=%b busy=%b start=%b err=%b n_out=%0d in_ready=%b",
               cfg_ready, busy, start, err, n_out, in_ready);
    end
    sys_rst_n = 1'b1;
    tick();
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset cfg_ready=%b busy=%b", cfg_ready, busy);
    end
  endtask

  task automatic test_basic;
    bit s;
    words.delete();
    for (int i = 1; i <= 8; i++) words.push_back(32'(i));
    run_job(32'd4, 1'b0, s);
    rd_addr_a = 8'd2; rd_addr_b = 8'd3; #1;
    total++;
    if (rd_data_a !== 32'd3) begin bad++; $display("FAIL basic_a2 got=%0d exp=3", rd_data_a); end
    total++;
    if (rd_data_b !== 32'd8) begin bad++; $display("FAIL basic_b3 got=%0d exp=8", rd_data_b); end
    finish_job(3);
  endtask

  task automatic test_zero;
    bit s;
    words.delete();
    run_job(32'd0, 1'b0, s);
    total++;
    if (s) begin bad++; $display("FAIL zero_in_ready got=1 exp=0"); end
    finish_job(2);
  endtask

  task automatic test_back_to_back;
    bit s;
    int n;
    repeat (4) begin
      n = $urandom_range(1, 20);
      fill_random(n);
      run_job(32'(n), 1'b0, s);
      finish_job($urandom_range(0, 4));
    end
  endtask

  task automatic test_clamp;
    bit s;
    fill_random(256);
    run_job(32'd300, 1'b0, s);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL clamp_err got=%b exp=1", err); end
    in_valid = 1'b1;
    in_data  = $urandom;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL beat_513_refused in_ready=%b exp=0", in_ready); end
    in_valid = 1'b0;
    rd_addr_a = 8'd255; rd_addr_b = 8'd255; #1;
    total++;
    if (rd_data_a !== words[255]) begin
      bad++; $display("FAIL clamp_a255 got=%h exp=%h", rd_data_a, words[255]);
    end
    total++;
    if (rd_data_b !== words[511]) begin
      bad++; $display("FAIL clamp_b255 got=%h exp=%h", rd_data_b, words[511]);
    end
    finish_job(1);
    total++;
    if (err !== 1'b1 || n_out !== 32'd256) begin
      bad++; $display("FAIL err_sticky err=%b n_out=%0d exp 1/256", err, n_out);
    end
  endtask

  task automatic test_gaps;
    bit s;
    repeat (3) begin
      fill_random(3);
      run_job(32'd3, 1'b1, s);
      finish_job(1);
    end
  endtask

  task automatic test_wait_cfg;
    bit s;
    fill_random(2);
    run_job(32'd2, 1'b0, s);
    cfg_valid = 1'b1;
    cfg_n = 32'd7;
    repeat (3) tick();
    cfg_valid = 1'b0;
    total++;
    if (n_out !== 32'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL wait_cfg_ignored n_out=%0d busy=%b exp 2/1", n_out, busy);
    end
    finish_job(0);
  endtask

  task automatic test_reset_mid_load;
    bit s;
    fill_random(4);
    do_cfg(32'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = words[i];
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || start !== 1'b0) begin
      bad++; $display("FAIL mid_load in_ready=%b start=%b exp 1/0", in_ready, start);
    end
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || n_out !== 32'd0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_load cfg_ready=%b busy=%b err=%b n_out=%0d in_ready=%b",
               cfg_ready, busy, err, n_out, in_ready);
    end
    tick();
    fill_random(2);
    run_job(32'd2, 1'b0, s);
    finish_job(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_clamp();
    test_gaps();
    test_wait_cfg();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
